// File: rtl/aes_trace_sequencer.sv
// -----------------------------------------------------------------------------
// aes_trace_sequencer
//
// Stimulus engine for AES side-channel capture campaigns. After an accepted
// cfg_go it runs cfg_num encryptions back to back on an external AES core.
// Each trace uses either the fixed plaintext or the current value of a
// 128-bit Galois LFSR. The class of each trace is picked by cfg_mode:
// fixed, random, alternating, or chosen by the LFSR MSB. Every start pulse
// comes with a scope trigger. After each trace there is a quiet gap, and a
// core that never answers is aborted after a timeout.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   cfg_go / cfg_stop    start a campaign (IDLE only) / stop after current trace
//   cfg_mode             0 fixed, 1 random, 2 alternating F/R, 3 LFSR-chosen F/R
//   cfg_num              number of traces, latched with cfg_go
//   cfg_key/cfg_fixed_pt key and fixed plaintext, latched with cfg_go
//   core_start           1-cycle start pulse to the AES core
//   core_key/plaintext   operands to the core, stable from start until done
//   core_done            core completion; the first high cycle in WAIT counts
//   core_ciphertext      core result, sampled with core_done
//   trig                 scope trigger, coincident with core_start
//   busy                 high whenever the sequencer is not idle
//   res_valid            1-cycle strobe qualifying res_ct/res_pt/res_class
//   trace_cnt            traces completed in the current campaign
//   done                 1-cycle pulse at the end of a campaign
//   err_timeout          sticky core-timeout flag, cleared by the next cfg_go
//   dbg_state_o          current FSM state (0 IDLE, 1 LOAD, 2 WAIT, 3 GAP)
//
// Handshake: core_start is a single-cycle request. The core answers with
// core_done, either as a level or as a pulse. Only the first high cycle
// seen in WAIT is consumed, and core_done is ignored in every other state.
// res_valid and done are single-cycle strobes with no back-pressure.
// -----------------------------------------------------------------------------
module aes_trace_sequencer #(
    parameter int unsigned  CNT_W      = 16,
    parameter int unsigned  GAP_CYCLES = 8,
    parameter int unsigned  TIMEOUT    = 64,
    parameter logic [127:0] LFSR_SEED  = 128'h1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_go,
    input  logic             cfg_stop,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_num,
    input  logic [127:0]     cfg_key,
    input  logic [127:0]     cfg_fixed_pt,
    output logic             core_start,
    output logic [127:0]     core_key,
    output logic [127:0]     core_plaintext,
    input  logic             core_done,
    input  logic [127:0]     core_ciphertext,
    output logic             trig,
    output logic             busy,
    output logic             res_valid,
    output logic [127:0]     res_ct,
    output logic [127:0]     res_pt,
    output logic             res_class,
    output logic [CNT_W-1:0] trace_cnt,
    output logic             done,
    output logic             err_timeout,
    output logic [1:0]       dbg_state_o
);

    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 2);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [127:0] SEED_EFF  = (LFSR_SEED == '0) ? 128'h1 : LFSR_SEED;
    // x^128 + x^7 + x^2 + x + 1, low-order taps.
    localparam logic [127:0] LFSR_POLY = 128'h87;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [127:0]       key_q, key_d;
    logic [127:0]       fpt_q, fpt_d;
    logic [127:0]       pt_q, pt_d;
    logic               class_q, class_d;
    logic [127:0]       lfsr_q, lfsr_d;
    logic [CNT_W-1:0]   trace_cnt_q, trace_cnt_d;
    logic [TO_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               stop_req_q, stop_req_d;
    logic               res_valid_q, res_valid_d;
    logic [127:0]       res_ct_q, res_ct_d;
    logic [127:0]       res_pt_q, res_pt_d;
    logic               res_class_q, res_class_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               go_acc;
    logic               num_zero;
    logic               trace_hit;
    logic               wait_to;
    logic               last_trace;
    logic [CNT_W-1:0]   cnt_inc;
    logic [127:0]       lfsr_step;
    logic               sel_class;

    assign go_acc     = (state_q == S_IDLE) && cfg_go;
    assign num_zero   = (cfg_num == '0);
    assign trace_hit  = (state_q == S_WAIT) && core_done;
    assign wait_to    = (state_q == S_WAIT) && !core_done && (wait_cnt_q == TO_LAST);
    assign cnt_inc    = trace_cnt_q + 1'b1;
    // A stop arriving in the same cycle as core_done still ends the campaign
    // after this trace, so the raw request is OR-ed in.
    assign last_trace = (cnt_inc == num_q) || stop_req_q || cfg_stop;
    assign lfsr_step  = {lfsr_q[126:0], 1'b0} ^ (lfsr_q[127] ? LFSR_POLY : '0);

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (go_acc && !num_zero) state_d = S_LOAD;
            end
            S_LOAD: state_d = S_WAIT;
            S_WAIT: begin
                if (core_done) begin
                    if (last_trace)            state_d = S_IDLE;
                    else if (GAP_CYCLES == 0)  state_d = S_LOAD;
                    else                       state_d = S_GAP;
                end else if (wait_cnt_q == TO_LAST) begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    // These are decoded straight from the state register. An asynchronous
    // reset therefore drops them immediately.
    always_comb begin
        core_start  = (state_q == S_LOAD);
        trig        = (state_q == S_LOAD);
        busy        = (state_q != S_IDLE);
        dbg_state_o = state_q;
    end

    // ---------------------------------------------------------------- datapath
    always_comb begin
        mode_d      = mode_q;
        num_d       = num_q;
        key_d       = key_q;
        fpt_d       = fpt_q;
        pt_d        = pt_q;
        class_d     = class_q;
        lfsr_d      = lfsr_q;
        trace_cnt_d = trace_cnt_q;
        stop_req_d  = stop_req_q;
        err_d       = err_q;
        res_valid_d = 1'b0;
        res_ct_d    = res_ct_q;
        res_pt_d    = res_pt_q;
        res_class_d = res_class_q;
        done_d      = 1'b0;
        sel_class   = 1'b0;

        if (go_acc) begin
            mode_d      = cfg_mode;
            num_d       = cfg_num;
            key_d       = cfg_key;
            fpt_d       = cfg_fixed_pt;
            trace_cnt_d = '0;
            stop_req_d  = 1'b0;
            err_d       = 1'b0;
            done_d      = num_zero;
        end else if ((state_q != S_IDLE) && cfg_stop) begin
            stop_req_d  = 1'b1;
        end

        if (trace_hit) begin
            res_valid_d = 1'b1;
            res_ct_d    = core_ciphertext;
            res_pt_d    = pt_q;
            res_class_d = class_q;
            trace_cnt_d = cnt_inc;
            done_d      = last_trace;
        end

        if (wait_to) begin
            err_d  = 1'b1;
            done_d = 1'b1;
        end

        // Both counters restart whenever their state is left, so entry needs no
        // explicit clear.
        wait_cnt_d = (state_q == S_WAIT) ? wait_cnt_q + 1'b1 : '0;
        gap_cnt_d  = (state_q == S_GAP)  ? gap_cnt_q + 1'b1  : '0;

        // The operand is chosen on entry to LOAD, so it is already stable when
        // core_start rises. Mode 2 uses the index of the trace about to run,
        // which is the updated completion count.
        if (state_d == S_LOAD) begin
            unique case (mode_d)
                2'd0:    sel_class = 1'b0;
                2'd1:    sel_class = 1'b1;
                2'd2:    sel_class = trace_cnt_d[0];
                default: sel_class = lfsr_q[127];
            endcase
            class_d = sel_class;
            pt_d    = sel_class ? lfsr_q : fpt_d;
            // The LFSR steps on every LOAD regardless of class, so the random
            // sequence does not depend on the mode.
            lfsr_d  = lfsr_step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= '0;
            num_q       <= '0;
            key_q       <= '0;
            fpt_q       <= '0;
            pt_q        <= '0;
            class_q     <= 1'b0;
            lfsr_q      <= SEED_EFF;
            trace_cnt_q <= '0;
            wait_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            stop_req_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_ct_q    <= '0;
            res_pt_q    <= '0;
            res_class_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            num_q       <= num_d;
            key_q       <= key_d;
            fpt_q       <= fpt_d;
            pt_q        <= pt_d;
            class_q     <= class_d;
            lfsr_q      <= lfsr_d;
            trace_cnt_q <= trace_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            stop_req_q  <= stop_req_d;
            res_valid_q <= res_valid_d;
            res_ct_q    <= res_ct_d;
            res_pt_q    <= res_pt_d;
            res_class_q <= res_class_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign core_key       = key_q;
    assign core_plaintext = pt_q;
    assign res_valid      = res_valid_q;
    assign res_ct         = res_ct_q;
    assign res_pt         = res_pt_q;
    assign res_class      = res_class_q;
    assign trace_cnt      = trace_cnt_q;
    assign done           = done_q;
    assign err_timeout    = err_q;

endmodule

// File: tb/tb_aes_trace_sequencer.sv
module tb_aes_trace_sequencer;

    localparam int           CNT_W = 16;
    localparam int           GAP   = 8;
    localparam int           TMO   = 64;
    localparam logic [127:0] SEED  = 128'hc0ffee00_12345678_9abcdef0_0badf00d;

    localparam logic [127:0] AES_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] AES_PT  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] AES_CT  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

    // ------------------------------------------------------------ clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ------------------------------------------------------------ DUT signals
    logic             cfg_go = 1'b0, cfg_stop = 1'b0;
    logic [1:0]       cfg_mode = '0;
    logic [CNT_W-1:0] cfg_num = '0;
    logic [127:0]     cfg_key = '0, cfg_fixed_pt = '0;
    logic             core_start, core_done = 1'b0;
    logic [127:0]     core_key, core_plaintext, core_ciphertext = '0;
    logic             trig, busy, res_valid, res_class, done, err_timeout;
    logic [127:0]     res_ct, res_pt;
    logic [CNT_W-1:0] trace_cnt;
    logic [1:0]       dbg_state_o;

    aes_trace_sequencer #(
        .CNT_W(CNT_W), .GAP_CYCLES(GAP), .TIMEOUT(TMO), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_go(cfg_go), .cfg_stop(cfg_stop),
        .cfg_mode(cfg_mode), .cfg_num(cfg_num), .cfg_key(cfg_key),
        .cfg_fixed_pt(cfg_fixed_pt), .core_start(core_start), .core_key(core_key),
        .core_plaintext(core_plaintext), .core_done(core_done),
        .core_ciphertext(core_ciphertext), .trig(trig), .busy(busy),
        .res_valid(res_valid), .res_ct(res_ct), .res_pt(res_pt),
        .res_class(res_class), .trace_cnt(trace_cnt), .done(done),
        .err_timeout(err_timeout), .dbg_state_o(dbg_state_o)
    );

    // ------------------------------------------------------------ checking
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------ reference model
    // Multiplication by x in GF(2^128) modulo x^128+x^7+x^2+x+1.
    function automatic logic [127:0] gf_mul_x(input logic [127:0] v);
        logic [127:0] r;
        r = v << 1;
        if (v[127]) r = r ^ 128'h87;
        return r;
    endfunction

    // Stand-in cipher: the real AES answer for the published vector,
    // otherwise an arbitrary but deterministic mix of key and plaintext.
    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
        if (k == AES_KEY && p == AES_PT) return AES_CT;
        return p ^ {k[63:0], k[127:64]} ^ 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_9696_6969;
    endfunction

    logic [127:0] m_lfsr = SEED;
    logic [1:0]   m_mode = '0;
    logic [127:0] m_key  = '0, m_fpt = '0;
    int           m_lat  = 1;

    logic [127:0] exp_q[$];
    logic [127:0] exp_pt_q[$];
    logic         exp_cls_q[$];

    // ------------------------------------------------------------ core model
    int           cd_cnt = 0;
    logic [127:0] cd_ct  = '0;
    bit           core_mute = 1'b0;

    always @(negedge clk) begin
        core_done       = 1'b0;
        core_ciphertext = {$urandom, $urandom, $urandom, $urandom};
        if (rst_n && core_start) begin
            cd_cnt = m_lat;
            cd_ct  = core_fn(core_key, core_plaintext);
        end else if (cd_cnt > 0) begin
            cd_cnt--;
            if (cd_cnt == 0 && !core_mute) begin
                core_done       = 1'b1;
                core_ciphertext = cd_ct;
            end
        end
    end

    // ------------------------------------------------------------ monitor / scoreboard
    int camp_starts = 0, last_start = 0, go_cyc = 0;
    int n_rv = 0, n_done = 0, done_cyc = 0;
    bit rv_at_done = 0, busy_at_done = 0, busy_seen = 0;

    always @(negedge clk) begin : mon
        logic         cls;
        logic [127:0] pt;
        if (rst_n) begin
            if (busy) busy_seen = 1'b1;
            if (trig !== core_start) check_eq("trig_eq_start", trig, core_start);
            if (core_start) begin
                case (m_mode)
                    2'd0:    cls = 1'b0;
                    2'd1:    cls = 1'b1;
                    2'd2:    cls = camp_starts[0];
                    default: cls = m_lfsr[127];
                endcase
                pt = cls ? m_lfsr : m_fpt;
                check_eq("core_plaintext", core_plaintext, pt);
                check_eq("core_key", core_key, m_key);
                if (camp_starts == 0) check_eq("first_start_lat", cyc - go_cyc, 1);
                else                  check_eq("start_spacing", cyc - last_start, m_lat + GAP + 1);
                exp_q.push_back(core_fn(m_key, pt));
                exp_pt_q.push_back(pt);
                exp_cls_q.push_back(cls);
                m_lfsr = gf_mul_x(m_lfsr);
                camp_starts++;
                last_start = cyc;
            end
            if (res_valid) begin
                n_rv++;
                if (exp_q.size() == 0) begin
                    check_eq("res_unexpected", 1, 0);
                end else begin
                    check_eq("res_ct", res_ct, exp_q.pop_front());
                    check_eq("res_pt", res_pt, exp_pt_q.pop_front());
                    check_eq("res_class", res_class, exp_cls_q.pop_front());
                    check_eq("res_trace_cnt", trace_cnt, n_rv);
                end
            end
            if (done) begin
                n_done++;
                done_cyc     = cyc;
                rv_at_done   = res_valid;
                busy_at_done = busy;
            end
        end
    end

    // ------------------------------------------------------------ driver tasks
    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send_go(input logic [1:0] mode, input int num, input logic [127:0] key,
                           input logic [127:0] fpt, input int lat, input bit mute);
        @(negedge clk); #1;
        m_mode = mode; m_key = key; m_fpt = fpt; m_lat = lat; core_mute = mute;
        camp_starts = 0; n_rv = 0; n_done = 0; busy_seen = 0; go_cyc = cyc;
        cfg_go = 1'b1; cfg_mode = mode; cfg_num = CNT_W'(num);
        cfg_key = key; cfg_fixed_pt = fpt;
        @(negedge clk); #1;
        // Scramble the configuration to show it was latched on go.
        cfg_go = 1'b0; cfg_mode = 2'($urandom); cfg_num = CNT_W'($urandom);
        cfg_key = rnd128(); cfg_fixed_pt = rnd128();
    endtask

    task automatic run_campaign(input logic [1:0] mode, input int num, input logic [127:0] key,
                                input logic [127:0] fpt, input int lat, input int stop_at,
                                input bit mute);
        int exp_n, waited;
        bit stop_sent, stray;
        send_go(mode, num, key, fpt, lat, mute);
        check_eq("err_cleared_on_go", err_timeout, 0);
        exp_n = mute ? 0 : (stop_at > 0 ? stop_at : num);
        waited = 0; stop_sent = 0; stray = 0;
        while (n_done == 0 && waited < 4000) begin
            @(negedge clk); #1;
            waited++;
            cfg_stop = 1'b0;
            cfg_go   = 1'b0;
            if (stop_at > 0 && !stop_sent && camp_starts == stop_at && cyc == last_start + 1) begin
                cfg_stop  = 1'b1;
                stop_sent = 1'b1;
            end
            // A go while busy must be ignored; the scrambled cfg stays applied.
            if (!stray && camp_starts == 1 && cyc == last_start + 1) begin
                cfg_go = 1'b1;
                stray  = 1'b1;
            end
        end
        cfg_stop = 1'b0;
        cfg_go   = 1'b0;
        check_eq("done_seen", n_done != 0, 1);
        check_eq("final_trace_cnt", trace_cnt, exp_n);
        check_eq("res_count", n_rv, exp_n);
        check_eq("err_timeout", err_timeout, mute);
        check_eq("busy_at_done", busy_at_done, 0);
        check_eq("res_valid_with_done", rv_at_done, exp_n > 0);
        check_eq("pending_expectations", exp_q.size(), mute ? 1 : 0);
        if (mute) check_eq("timeout_latency", done_cyc - last_start, TMO + 1);
        if (num == 0) begin
            check_eq("num0_done_latency", done_cyc - go_cyc, 1);
            check_eq("num0_no_start", camp_starts, 0);
            check_eq("num0_busy_never", busy_seen, 0);
        end
        exp_q.delete(); exp_pt_q.delete(); exp_cls_q.delete();
        @(negedge clk); #1;
        check_eq("done_single_pulse", done, 0);
    endtask

    task automatic mid_reset(input bit in_load);
        send_go(2'd1, 5, rnd128(), rnd128(), 10, 1'b0);
        // send_go returns inside the LOAD cycle.
        if (!in_load) begin
            repeat (3) @(negedge clk);
            #1;
        end
        check_eq(in_load ? "start_before_reset" : "busy_before_reset",
                 in_load ? core_start : busy, 1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_core_start", core_start, 0);
        check_eq("rst_trig", trig, 0);
        check_eq("rst_busy", busy, 0);
        cd_cnt = 0; core_done = 1'b0;
        exp_q.delete(); exp_pt_q.delete(); exp_cls_q.delete();
        m_lfsr = SEED; camp_starts = 0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------ main sequence
    initial begin : main
        int mode, num, lat, stp;
        repeat (3) @(negedge clk);
        check_eq("reset_core_start", core_start, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_res_valid", res_valid, 0);
        check_eq("reset_trace_cnt", trace_cnt, 0);
        check_eq("reset_core_key", core_key, 0);
        check_eq("reset_err", err_timeout, 0);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_after_release", busy, 0);

        run_campaign(2'd0, 1, AES_KEY, AES_PT, 5, 0, 1'b0);
        run_campaign(2'd2, 4, rnd128(), rnd128(), 3, 0, 1'b0);
        run_campaign(2'd0, 0, rnd128(), rnd128(), 3, 0, 1'b0);
        run_campaign(2'd1, 100, rnd128(), rnd128(), 4, 3, 1'b0);
        // Stop arriving in the same cycle as core_done (latency 1).
        run_campaign(2'd3, 10, rnd128(), rnd128(), 1, 2, 1'b0);
        run_campaign(2'd0, 3, rnd128(), rnd128(), 2, 0, 1'b1);

        for (int i = 0; i < 12; i++) begin
            mode = $urandom_range(0, 3);
            num  = $urandom_range(1, 5);
            lat  = $urandom_range(1, 6);
            stp  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, num) : 0;
            run_campaign(2'(mode), num, rnd128(), rnd128(), lat, stp, 1'b0);
        end

        mid_reset(1'b0);
        mid_reset(1'b1);
        run_campaign(2'd2, 3, rnd128(), rnd128(), 2, 0, 1'b0);
        run_campaign(2'd3, 4, rnd128(), rnd128(), 3, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

endmodule
